// File: rtl/data_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_stage
// Purpose  : Y86-64 memory stage. Performs loads and stores against an internal
//            word array, flags bad addresses and stalls upstream during wait states.
// Revision : 1.0  initial release
// ============================================================================
module data_memory_stage #(
    parameter int MEM_WORDS   = 8192,
    parameter int WAIT_CYCLES = 0,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        init_we,
    input  logic [63:0] init_addr,
    input  logic [63:0] init_data,
    output logic [2:0]  m_stat,
    output logic [3:0]  m_icode,
    output logic [63:0] m_valE,
    output logic [63:0] m_valM,
    output logic [3:0]  m_dstE,
    output logic [3:0]  m_dstM,
    output logic        m_busy
);

    localparam logic [2:0]  c_SAOK      = 3'd1;
    localparam logic [2:0]  c_SADR      = 3'd2;
    localparam logic [3:0]  c_INOP      = 4'h1;
    localparam logic [3:0]  c_IRMMOVQ   = 4'h4;
    localparam logic [3:0]  c_IMRMOVQ   = 4'h5;
    localparam logic [3:0]  c_ICALL     = 4'h8;
    localparam logic [3:0]  c_IRET      = 4'h9;
    localparam logic [3:0]  c_IPUSHQ    = 4'hA;
    localparam logic [3:0]  c_IPOPQ     = 4'hB;
    localparam logic [3:0]  c_RNONE     = 4'hF;
    localparam int          c_IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [63:0] c_MEM_BYTES = 64'(MEM_WORDS) << 3;
    localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    logic [63:0]        r_mem [MEM_WORDS];
    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;

    logic [2:0]         r_stat,  w_stat_nxt;
    logic [3:0]         r_icode, w_icode_nxt;
    logic [63:0]        r_valE,  w_valE_nxt;
    logic [63:0]        r_valM,  w_valM_nxt;
    logic [3:0]         r_dstE,  w_dstE_nxt;
    logic [3:0]         r_dstM,  w_dstM_nxt;

    logic               w_is_read;
    logic               w_is_write;
    logic [63:0]        w_addr;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_init_idx;
    logic               w_init_ok;
    logic               w_fault;
    logic               w_real;
    logic               w_busy;
    logic               w_complete;
    logic               w_mem_we;
    logic               w_unused_ok;

    always_comb begin
        w_is_read  = (M_icode == c_IMRMOVQ) || (M_icode == c_IPOPQ) || (M_icode == c_IRET);
        w_is_write = (M_icode == c_IRMMOVQ) || (M_icode == c_IPUSHQ) || (M_icode == c_ICALL);
        w_addr     = ((M_icode == c_IPOPQ) || (M_icode == c_IRET)) ? M_valA : M_valE;
        w_idx      = w_addr[c_IDX_W+2:3];
        w_init_idx = init_addr[c_IDX_W+2:3];
        w_init_ok  = init_addr < c_MEM_BYTES;
        // Full 64-bit compare so oversized addresses can never alias low words.
        w_fault    = (w_addr >= c_MEM_BYTES) || (ALIGN_CHECK && (w_addr[2:0] != 3'd0));
        w_real     = (w_is_read || w_is_write) && (M_stat == c_SAOK) && !w_fault;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy      = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_real && (WAIT_CYCLES != 0)) begin
                    w_busy      = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_WAIT_INIT;
                end else begin
                    w_complete  = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_busy      = 1'b1;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        // Any non-completing cycle presents a bubble downstream.
        w_stat_nxt  = c_SAOK;
        w_icode_nxt = c_INOP;
        w_valE_nxt  = 64'd0;
        w_valM_nxt  = 64'd0;
        w_dstE_nxt  = c_RNONE;
        w_dstM_nxt  = c_RNONE;
        if (w_complete) begin
            w_stat_nxt  = ((w_is_read || w_is_write) && (M_stat == c_SAOK) && w_fault)
                          ? c_SADR : M_stat;
            w_icode_nxt = M_icode;
            w_valE_nxt  = M_valE;
            w_valM_nxt  = (w_real && w_is_read) ? r_mem[w_idx] : 64'd0;
            w_dstE_nxt  = M_dstE;
            w_dstM_nxt  = M_dstM;
        end
        w_mem_we = w_complete && w_real && w_is_write && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_stat  <= c_SAOK;
            r_icode <= c_INOP;
            r_valE  <= 64'd0;
            r_valM  <= 64'd0;
            r_dstE  <= c_RNONE;
            r_dstM  <= c_RNONE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stat  <= w_stat_nxt;
            r_icode <= w_icode_nxt;
            r_valE  <= w_valE_nxt;
            r_valM  <= w_valM_nxt;
            r_dstE  <= w_dstE_nxt;
            r_dstM  <= w_dstM_nxt;
        end
    end

    // Array is not reset; the pipeline write is last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (init_we && w_init_ok) begin
            r_mem[w_init_idx] <= init_data;
        end
        if (w_mem_we) begin
            r_mem[w_idx] <= M_valA;
        end
    end

    assign w_unused_ok = ^init_addr[2:0];

    assign m_stat  = r_stat;
    assign m_icode = r_icode;
    assign m_valE  = r_valE;
    assign m_valM  = r_valM;
    assign m_dstE  = r_dstE;
    assign m_dstM  = r_dstM;
    assign m_busy  = w_busy;

endmodule
`default_nettype wire

// File: doc/data_memory_stage.md
# data_memory_stage

Parametrised memory stage of the Y86-64 pipeline, between the M pipeline register and the W register. Performs loads for mrmovq/popq/ret and stores for rmmovq/pushq/call against an internal 64-bit word array. Detects out-of-range and misaligned addresses. Supports a configurable number of memory wait states, which it signals upstream through a stall output.

## Interface

Parameters:

- MEM_WORDS, 8192: number of 64-bit words in the array; valid byte addresses are 0 .. MEM_WORDS*8-1.
- WAIT_CYCLES, 0: extra cycles per memory access (0..15); 0 gives single-cycle access.
- ALIGN_CHECK, 1: when 1, a memory address with addr[2:0]!=0 is a fault.

Ports:

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- M_stat  in  3  status from M register
- M_icode  in  4  instruction code
- M_valE  in  64  ALU result / address
- M_valA  in  64  store data / pop-ret address
- M_dstE  in  4  E destination register
- M_dstM  in  4  M destination register
- init_we  in  1  backdoor write enable (bench/loader)
- init_addr  in  64  backdoor byte address (word index = addr>>3)
- init_data  in  64  backdoor write data
- m_stat  out  3  registered status
- m_icode  out  4  registered icode
- m_valE  out  64  registered valE
- m_valM  out  64  registered load data
- m_dstE  out  4  registered dstE
- m_dstM  out  4  registered dstM
- m_busy  out  1  combinational; 1 = hold M register and upstream this cycle

## Operation

- Encodings: SAOK=1, SADR=2, SINS=3, SHLT=4; INOP=1; RNONE=15.
- Address selection: mrmovq, rmmovq, pushq and call use M_valE. popq and ret use M_valA.
- Read ops: mrmovq, popq, ret. Write ops: rmmovq, pushq, call (data = M_valA). These six are "mem ops".
- Fault: the address is >= MEM_WORDS*8, or (ALIGN_CHECK and addr[2:0]!=0).
- On a fault:
  - m_stat=SADR and m_valM=0.
  - No write occurs.
  - Other fields pass through.
- If M_stat!=SAOK, no access is performed, no stall occurs, and every field passes through with m_valM=0.
- Non-mem ops pass through in one edge with m_valM=0.
- Real access: a mem op with M_stat==SAOK and no fault.
- Reset does not alter array contents; simulation initialises the array to 0.
- Backdoor writes take effect on any edge. If a backdoor write and a pipeline write hit the same word on the same edge, the pipeline write wins.
- FSM states: IDLE and WAIT, with a 4-bit counter cnt.
  - IDLE, with a real access and WAIT_CYCLES>0: m_busy=1. At the edge, go to WAIT with cnt=WAIT_CYCLES-1 and load bubble outputs.
  - IDLE, otherwise: m_busy=0. At the edge, complete: perform the access and register the outputs.
  - WAIT, cnt!=0: m_busy=1. At the edge, cnt decrements and bubble outputs are held.
  - WAIT, cnt==0: m_busy=0. At the edge, complete the access (read or write), register the outputs, and return to IDLE.
- Bubble outputs: m_stat=SAOK, m_icode=INOP, m_valE=0, m_valM=0, m_dstE=RNONE, m_dstM=RNONE.
- Upstream must hold all M_* inputs stable while m_busy=1. The block samples the address and data at the completing edge.

## Timing

- Reset values: every output takes its bubble value, m_busy=0, state=IDLE, cnt=0.
- Reset asserted in WAIT aborts the access; the pending write is never performed.
- Latency for non-mem, faulting or non-SAOK instructions: outputs are valid after 1 edge.
- Latency for a real access: outputs are valid after WAIT_CYCLES+1 edges.
  - m_busy is high for exactly WAIT_CYCLES cycles.
  - Throughput is one access per WAIT_CYCLES+1 cycles.
- Write timing: the write commits on the completing edge. A load of the same word presented in the next cycle returns the new data.
- Load data is read from the array at the completing edge and is visible on m_valM immediately after it.
- Address comparison is done on the full 64 bits, so huge addresses fault and never wrap.

## Test plan

- WAIT_CYCLES=0: rmmovq with valE=0x40, valA=0xDEAD, then mrmovq with valE=0x40 and dstM=3 -> m_valM=0xDEAD and m_dstM=3 one edge after the load; m_busy stays 0.
- WAIT_CYCLES=3: popq with valA=0x100 (word preloaded via init = 0x55) -> m_busy high for 3 cycles with bubble outputs, then m_icode=IPOPQ, m_valM=0x55, m_stat=SAOK on the 4th edge.
- Faults:
  - mrmovq with valE=MEM_WORDS*8 -> m_stat=SADR, m_valM=0.
  - rmmovq with valE=0x41 (ALIGN_CHECK=1) -> SADR, word 0x40 unchanged.
  - Neither case raises m_busy.
- M_stat=SHLT with icode=rmmovq -> passes through as SHLT, no write (verified by a read-back), no stall.
- WAIT_CYCLES=2: reset asserted during WAIT on a pushq -> outputs take bubble values next edge, m_busy=0, target word unchanged.
- Backdoor and pipeline writes to the same word on the same edge -> read-back returns the pipeline data.
